phy_dly_loader: RTL and testbench
=================================

# phy_dly_loader

Delay-programming sequencer for the DDR3 PHY byte lane's IODELAY load interface (`dly_addr`/`dly_data`/`ld_delay`/`set`). It keeps a shadow copy of all 19 per-lane delay values (8 DQ outputs, DQS output, DM output, 8 DQ inputs, DQS input), each with a dirty bit. On command it sweeps the address space and issues one `ld_delay` strobe per dirty entry, then a single `set` pulse, so all new delays take effect together. It sits between the control register block and one byte lane.

## Interface
Parameters:
- `DLY_WIDTH`, 8: delay value width (3 LSB are the fine delay).
- `ADDR_WIDTH`, 5: delay address width. Bit 4 selects input (1) or output (0) delays.

Ports:
- `clk_div`, in, 1: PHY half-rate clock. Every signal is synchronous to it.
- `rst_n`, in, 1: synchronous, active-low reset.
- `wr_en`, in, 1: write `wr_data` into shadow entry `wr_addr` and mark it dirty.
- `wr_addr`, in, 5: shadow address.
- `wr_data`, in, 8: delay value.
- `apply`, in, 1: start a sweep that loads the dirty entries.
- `apply_all`, in, 1: mark all valid entries dirty and start a sweep.
- `rd_addr`, in, 5: readback address.
- `rd_data`, out, 8: shadow value at `rd_addr`, registered.
- `busy`, out, 1: sweep in progress.
- `done`, out, 1: one-cycle pulse when a sweep completes.
- `dly_addr`, out, 5: to byte lane.
- `dly_data`, out, 8: to byte lane.
- `ld_delay`, out, 1: to byte lane, one-cycle load strobe.
- `set`, out, 1: to byte lane, one-cycle apply strobe.

## Operation
- **Valid addresses:** 0–9 (outputs: 0–7 DQ, 8 DQS, 9 DM) and 16–24 (inputs: 16–23 DQ, 24 DQS).
  - Writes to 10–15 and 25–31 are ignored. They store nothing and set no dirty bit.
  - Reading an invalid address returns 0.
- **Shadow storage:** 32×8 array plus a 32-bit dirty vector. Invalid entries are held at 0 and never dirty.
- **State machine:** IDLE → SCAN → SET → DONE → IDLE.
  - IDLE: `apply` or `apply_all` moves to SCAN with `ptr`=0. `apply_all` also ORs the valid mask into the dirty vector at the same edge. If both are high, the request behaves as `apply_all`.
  - SCAN: `ptr` advances by 1 per cycle from 0 to 31. If `dirty[ptr]`:
    - register `dly_addr`=`ptr`, `dly_data`=`mem[ptr]`, `ld_delay`=1;
    - clear `dirty[ptr]`.
    - Otherwise `ld_delay`=0, and `dly_addr`/`dly_data` hold their last values.
    - After `ptr`=31 the FSM moves to SET.
  - SET: register `set`=1 for one cycle, then move to DONE.
  - DONE: register `done`=1 for one cycle, then return to IDLE.
- **Sweep length:** fixed, independent of how many entries are dirty. The `set` pulse is issued even when zero entries are loaded.
- **`busy`:** 1 while the state is SCAN or SET. It is 0 in DONE, so it deasserts in the same cycle `done` pulses.
- **`apply`/`apply_all` while not IDLE:** ignored. `apply_all` then sets no dirty bits either.
- **`wr_en` during a sweep:** always accepted.
  - An address above `ptr` is picked up later in the same sweep.
  - An address already passed stays dirty for the next sweep.
  - A write to the same address being scanned in that cycle: the outputs carry the old data, and the write wins (dirty stays 1, memory holds the new value).
- **`wr_en` together with `apply` in IDLE:** the write is included in that sweep.
- **Readback:** `rd_data` = `mem[rd_addr]`, one-cycle latency. A same-cycle write is not bypassed; the old value is returned.
- **Reset (`rst_n`=0 at an edge):**
  - mem = 0, dirty = 0, state = IDLE, `ptr` = 0;
  - `dly_addr`=0, `dly_data`=0, `ld_delay`=0, `set`=0, `busy`=0, `done`=0, `rd_data`=0.
  - Reset in mid-sweep aborts it: no further `ld_delay`, and no `set` or `done`.

## Timing
- All outputs are registered.
- `apply` sampled at edge E0:
  - `busy`=1 after E0;
  - the entry for address k is on the outputs after edge E(k+1), for k = 0..31;
  - `set`=1 after E33 (`busy` still 1);
  - `done`=1 and `busy`=0 after E34;
  - a new `apply` is accepted at E35.
- `ld_delay` and `set` are never high together. `set` follows the last possible `ld_delay` by at least one cycle, as the byte lane requires.

## Test plan
- **Reset values:** hold `rst_n`=0 for 2 cycles, release → every output 0; `rd_data` for addresses 0..31 all 0.
- **Two-entry load:** write addr 3=0x5A and addr 17=0xC3, then `apply` at E0 → `ld_delay` high exactly twice: after E4 (`dly_addr`=3, `dly_data`=0x5A) and after E18 (17, 0xC3). `set` after E33; `done` after E34; a second `apply` produces no `ld_delay`.
- **`apply_all` after reset:** 19 `ld_delay` pulses, addresses 0–9 then 16–24, all with data 0, then `set` and `done`.
- **Invalid write:** write addr 12=0xFF → `rd_data`(12)=0; a following `apply` produces no `ld_delay`.
- **Write during sweep:**
  - write addr 20=0x11 at E5 → loaded after E21 in the same sweep;
  - write addr 2=0x22 at E10 → not loaded in this sweep, loaded by the next `apply`;
  - `apply` at E7 → ignored.
- **Reset mid-sweep:** dirty entries at 5 and 23, `apply` at E0, `rst_n`=0 at E10 → after E10 all outputs 0. Address 5 was already loaded; address 23 is never loaded; no `set` or `done`. After release, `apply` produces no `ld_delay`, because dirty was cleared.

Source files
------------

// File: rtl/phy_dly_loader.sv
// Delay-programming sequencer for one DDR3 PHY byte lane.
// Keeps a shadow of the 19 per-lane IODELAY values with dirty bits. On
// request it sweeps the full address space, strobes ld_delay once per dirty
// entry, then pulses set so every new delay takes effect together.
module phy_dly_loader #(
    parameter int DLY_WIDTH  = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_div,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DLY_WIDTH-1:0]  wr_data,
    input  logic                  apply,
    input  logic                  apply_all,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DLY_WIDTH-1:0]  rd_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] dly_addr,
    output logic [DLY_WIDTH-1:0]  dly_data,
    output logic                  ld_delay,
    output logic                  set
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_SET  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                 state_reg;
    logic [ADDR_WIDTH-1:0]  ptr_reg;
    logic [DEPTH-1:0]       dirty_reg;
    logic [DEPTH-1:0]       dirty_next;
    logic [DEPTH-1:0]       valid_mask;
    logic [DLY_WIDTH-1:0]   mem [DEPTH];
    logic                   wr_ok;

    // Outputs 0-9 (DQ0-7, DQS, DM) and inputs 16-24 (DQ0-7, DQS) exist in the lane
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_valid
            assign valid_mask[gi] = (gi <= 9) || ((gi >= 16) && (gi <= 24));
        end
    endgenerate

    assign wr_ok = wr_en && valid_mask[wr_addr];

    // Dirty bookkeeping: a write landing on the entry being scanned wins, so it stays dirty
    always_comb begin
        dirty_next = dirty_reg;
        if ((state_reg == ST_IDLE) && apply_all) begin
            dirty_next = dirty_next | valid_mask;
        end
        if (state_reg == ST_SCAN) begin
            dirty_next[ptr_reg] = 1'b0;
        end
        if (wr_ok) begin
            dirty_next[wr_addr] = 1'b1;
        end
    end

    // Shadow storage; invalid addresses never store, so they read back as 0
    always_ff @(posedge clk_div) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered readback, no write bypass
    always_ff @(posedge clk_div) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

    // Sweep sequencer with registered byte-lane outputs
    always_ff @(posedge clk_div) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            dirty_reg <= '0;
            dly_addr  <= '0;
            dly_data  <= '0;
            ld_delay  <= 1'b0;
            set       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            dirty_reg <= dirty_next;
            ld_delay  <= 1'b0;
            set       <= 1'b0;
            done      <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (apply || apply_all) begin
                        state_reg <= ST_SCAN;
                        ptr_reg   <= '0;
                        busy      <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (dirty_reg[ptr_reg]) begin
                        dly_addr <= ptr_reg;
                        dly_data <= mem[ptr_reg];
                        ld_delay <= 1'b1;
                    end
                    ptr_reg <= ptr_reg + 1'b1;
                    if (ptr_reg == PTR_LAST) begin
                        state_reg <= ST_SET;
                    end
                end
                ST_SET: begin
                    set       <= 1'b1;
                    state_reg <= ST_DONE;
                end
                ST_DONE: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phy_dly_loader.sv
// Directed bench for phy_dly_loader: a readback/write vector table plus
// cycle-by-cycle sweep sequences with hand-computed expectations.
module tb_phy_dly_loader;

    logic       clk_div = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       apply;
    logic       apply_all;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic [4:0] dly_addr;
    logic [7:0] dly_data;
    logic       ld_delay;
    logic       set;

    int checks = 0;
    int errors = 0;

    logic [4:0] last_a;
    logic [7:0] last_d;
    logic [7:0] exp_data [32];

    typedef struct {
        logic       we;
        logic [4:0] wa;
        logic [7:0] wd;
        logic [4:0] ra;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t tbl [8];

    always #5 clk_div = ~clk_div;

    phy_dly_loader #(.DLY_WIDTH(8), .ADDR_WIDTH(5)) dut (
        .clk_div  (clk_div),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .apply    (apply),
        .apply_all(apply_all),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .dly_addr (dly_addr),
        .dly_data (dly_data),
        .ld_delay (ld_delay),
        .set      (set)
    );

    task automatic tick();
        @(posedge clk_div);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n  = 1'b1;
        last_a = '0;
        last_d = '0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 32; i++) exp_data[i] = 8'h00;
    endtask

    // Drives edges E0..E34 of one sweep and checks outputs after each edge.
    // Edge arguments of -1 mean "not used".
    task automatic do_sweep(input string tag, input logic [31:0] mask, input logic all,
                            input int w1_e, input logic [4:0] w1_a, input logic [7:0] w1_d,
                            input int w2_e, input logic [4:0] w2_a, input logic [7:0] w2_d,
                            input int ap_e, input int rst_e);
        logic exp_ld, exp_busy, exp_set, exp_done;
        for (int e = 0; e <= 34; e++) begin
            apply     = ((e == 0) && !all) || (e == ap_e);
            apply_all = (e == 0) && all;
            wr_en     = 1'b0;
            if (e == w1_e) begin wr_en = 1'b1; wr_addr = w1_a; wr_data = w1_d; end
            if (e == w2_e) begin wr_en = 1'b1; wr_addr = w2_a; wr_data = w2_d; end
            rst_n = (e != rst_e);
            tick();
            apply = 1'b0; apply_all = 1'b0; wr_en = 1'b0; rst_n = 1'b1;
            exp_ld = 1'b0; exp_busy = 1'b0; exp_set = 1'b0; exp_done = 1'b0;
            if ((rst_e >= 0) && (e >= rst_e)) begin
                last_a = '0;
                last_d = '0;
            end else if (e <= 32) begin
                exp_busy = 1'b1;
                if (e >= 1) begin
                    exp_ld = mask[e-1];
                    if (exp_ld) begin
                        last_a = 5'(e - 1);
                        last_d = exp_data[e-1];
                    end
                end
            end else if (e == 33) begin
                exp_busy = 1'b1;
                exp_set  = 1'b1;
            end else begin
                exp_done = 1'b1;
            end
            chk($sformatf("%s ld_delay E%0d", tag, e), 32'(ld_delay), 32'(exp_ld));
            chk($sformatf("%s dly_addr E%0d", tag, e), 32'(dly_addr), 32'(last_a));
            chk($sformatf("%s dly_data E%0d", tag, e), 32'(dly_data), 32'(last_d));
            chk($sformatf("%s busy E%0d", tag, e), 32'(busy), 32'(exp_busy));
            chk($sformatf("%s set E%0d", tag, e), 32'(set), 32'(exp_set));
            chk($sformatf("%s done E%0d", tag, e), 32'(done), 32'(exp_done));
        end
        $display("sweep %s: mask=0x%08h apply_all=%0d reset_edge=%0d", tag, mask, all, rst_e);
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        apply = 1'b0; apply_all = 1'b0; rd_addr = '0;
        clear_exp();

        // Reset values
        do_reset();
        chk("rst ld_delay", 32'(ld_delay), 32'h0);
        chk("rst set", 32'(set), 32'h0);
        chk("rst done", 32'(done), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst dly_addr", 32'(dly_addr), 32'h0);
        chk("rst dly_data", 32'(dly_data), 32'h0);
        chk("rst rd_data", 32'(rd_data), 32'h0);
        for (int i = 0; i < 32; i++) begin
            rd_addr = 5'(i);
            tick();
            chk($sformatf("rst readback %0d", i), 32'(rd_data), 32'h0);
        end
        $display("reset: outputs and 32 readbacks checked");

        // Write / readback table (read is registered, no same-cycle bypass)
        tbl[0] = '{1'b1, 5'd3,  8'h5A, 5'd3,  8'h00};
        tbl[1] = '{1'b1, 5'd17, 8'hC3, 5'd3,  8'h5A};
        tbl[2] = '{1'b1, 5'd12, 8'hFF, 5'd17, 8'hC3};
        tbl[3] = '{1'b0, 5'd0,  8'h00, 5'd12, 8'h00};
        tbl[4] = '{1'b1, 5'd31, 8'h77, 5'd12, 8'h00};
        tbl[5] = '{1'b0, 5'd0,  8'h00, 5'd31, 8'h00};
        tbl[6] = '{1'b0, 5'd0,  8'h00, 5'd17, 8'hC3};
        tbl[7] = '{1'b0, 5'd0,  8'h00, 5'd3,  8'h5A};
        for (int i = 0; i < 8; i++) begin
            wr_en   = tbl[i].we;
            wr_addr = tbl[i].wa;
            wr_data = tbl[i].wd;
            rd_addr = tbl[i].ra;
            tick();
            wr_en = 1'b0;
            chk($sformatf("tbl%0d rd_data", i), 32'(rd_data), 32'(tbl[i].exp_rd));
            chk($sformatf("tbl%0d ld_delay", i), 32'(ld_delay), 32'h0);
            chk($sformatf("tbl%0d busy", i), 32'(busy), 32'h0);
            $display("vec %0d: we=%0d wa=%0d wd=0x%02h ra=%0d rd=0x%02h", i,
                     tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra, rd_data);
        end

        // Two-entry load, then a sweep with nothing dirty
        clear_exp();
        exp_data[3]  = 8'h5A;
        exp_data[17] = 8'hC3;
        do_sweep("two_entry", 32'h0002_0008, 1'b0, -1, 5'd0, 8'h00, -1, 5'd0, 8'h00, -1, -1);
        do_sweep("empty", 32'h0, 1'b0, -1, 5'd0, 8'h00, -1, 5'd0, 8'h00, -1, -1);

        // apply_all after reset
        do_reset();
        clear_exp();
        do_sweep("apply_all", 32'h01FF_03FF, 1'b1, -1, 5'd0, 8'h00, -1, 5'd0, 8'h00, -1, -1);

        // Invalid write stores nothing and marks nothing dirty
        wr(5'd12, 8'hFF);
        rd_addr = 5'd12;
        tick();
        chk("invalid rd12", 32'(rd_data), 32'h0);
        do_sweep("invalid", 32'h0, 1'b0, -1, 5'd0, 8'h00, -1, 5'd0, 8'h00, -1, -1);

        // Writes during sweep: 20 ahead of ptr, 2 behind ptr, apply while busy ignored
        exp_data[20] = 8'h11;
        do_sweep("wr_during", 32'h0010_0000, 1'b0, 5, 5'd20, 8'h11, 10, 5'd2, 8'h22, 7, -1);
        exp_data[2] = 8'h22;
        do_sweep("wr_behind", 32'h0000_0004, 1'b0, -1, 5'd0, 8'h00, -1, 5'd0, 8'h00, -1, -1);

        // Write to the entry being scanned: old data goes out, entry stays dirty
        wr(5'd20, 8'h44);
        exp_data[20] = 8'h44;
        do_sweep("collide", 32'h0010_0000, 1'b0, 21, 5'd20, 8'h55, -1, 5'd0, 8'h00, -1, -1);
        exp_data[20] = 8'h55;
        do_sweep("collide_next", 32'h0010_0000, 1'b0, -1, 5'd0, 8'h00, -1, 5'd0, 8'h00, -1, -1);

        // Reset mid-sweep: 5 loads, 23 never does, no set/done, dirty cleared
        wr(5'd5, 8'h05);
        wr(5'd23, 8'h23);
        exp_data[5]  = 8'h05;
        exp_data[23] = 8'h23;
        do_sweep("rst_mid", 32'h0080_0020, 1'b0, -1, 5'd0, 8'h00, -1, 5'd0, 8'h00, -1, 10);
        do_sweep("after_rst", 32'h0, 1'b0, -1, 5'd0, 8'h00, -1, 5'd0, 8'h00, -1, -1);
        rd_addr = 5'd23;
        tick();
        chk("after_rst rd23", 32'(rd_data), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
